icedemo_counter_checker: RTL and testbench

Receive-side consumer for the demo's free-running 16-bit counter stream carried over the PonyLink half-duplex link. It sits on the receive stream port of either link end (master or slave) in the iCE demo top. It accepts words, verifies that each equals the previous word plus one (modulo 2^WIDTH), and reports lock, stall and error status on the board LEDs. It is the reader counterpart of the counter generator that feeds the send stream.

---
 rtl/icedemo_counter_checker_if.sv | 23 ++
 rtl/icedemo_counter_checker.sv | 152 +++++++++++++++
 tb/tb_icedemo_counter_checker.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icedemo_counter_checker_if.sv
// Receive stream bundle for the iCE demo counter checker.
// The master drives words (tvalid/tdata); the slave answers with tready.
// A word moves on a rising edge where tvalid && tready.

interface icedemo_counter_checker_if #(
    parameter int WIDTH = 16
);
    logic             tvalid;
    logic             tready;
    logic [WIDTH-1:0] tdata;

    modport master (
        output tvalid,
        output tdata,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        output tready
    );
endinterface

// File: rtl/icedemo_counter_checker.sv
// icedemo_counter_checker
// Receive-side consumer of the demo's free-running counter stream. Every
// accepted word must equal the previous accepted word plus one (modulo
// 2^WIDTH). The checker hunts for LOCK_COUNT consecutive increments, then
// reports lock, stall (no traffic for TIMEOUT cycles while locked) and
// mismatch errors on the board LEDs.
//
// Optional build macro: ICEDEMO_CHECKER_THROTTLE_EN
//   defined   -> recv.tready toggles every clock (0 in reset, 1 on the first
//                cycle after release) to exercise link backpressure.
//   undefined -> recv.tready is tied high; no throttle logic exists.

module icedemo_counter_checker #(
    parameter int WIDTH      = 16,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 1000000
) (
    input  logic                      clk,
    input  logic                      resetn,
    icedemo_counter_checker_if.slave  recv,
    output logic                      locked,
    output logic                      stall,
    output logic                      err_sticky,
    output logic [7:0]                err_count,
    output logic [WIDTH-1:0]          last_word,
    output logic [7:0]                leds
);

    // Idle counter only has to reach TIMEOUT-1, so $clog2(TIMEOUT) bits suffice.
    localparam int                IDLE_W    = $clog2(TIMEOUT);
    localparam logic [7:0]        RUN_LAST  = 8'(LOCK_COUNT - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        EMPTY,
        HUNT,
        LOCKED,
        STALL
    } state_t;

    state_t            state;
    logic [7:0]        run_cnt;
    logic [IDLE_W-1:0] idle_cnt;

    logic              xfer;
    logic              in_seq;
    logic [7:0]        err_count_inc;

    assign xfer   = recv.tvalid && recv.tready;
    // Equality is evaluated at WIDTH bits, so all-ones followed by zero wraps cleanly.
    assign in_seq = (recv.tdata == last_word + WIDTH'(1));
    assign err_count_inc = (err_count == 8'hFF) ? err_count : err_count + 8'd1;

    // LED bank is pure wiring of registered state and data bits.
    assign leds = {locked, stall, err_sticky, last_word[WIDTH-1:WIDTH-5]};

`ifdef ICEDEMO_CHECKER_THROTTLE_EN
    logic tready_q;

    // Alternate ready every clock; low while in reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tready_q <= 1'b0;
        end else begin
            tready_q <= ~tready_q;
        end
    end

    assign recv.tready = tready_q;
`else
    assign recv.tready = 1'b1;
`endif

    // Lock/stall/error state machine with registered status outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= EMPTY;
            locked     <= 1'b0;
            stall      <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= 8'd0;
            last_word  <= '0;
            run_cnt    <= 8'd0;
            idle_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register below sees the
            // pre-edge values of its neighbours, whatever the statement order.
            if (xfer) begin
                last_word <= recv.tdata;
                idle_cnt  <= '0;
            end

            unique case (state)
                EMPTY: begin
                    if (xfer) begin
                        run_cnt <= 8'd0;
                        state   <= HUNT;
                    end
                end

                HUNT: begin
                    if (xfer) begin
                        if (!in_seq) begin
                            run_cnt <= 8'd0;
                        end else if (run_cnt == RUN_LAST) begin
                            run_cnt <= 8'd0;
                            state   <= LOCKED;
                            locked  <= 1'b1;
                        end else begin
                            run_cnt <= run_cnt + 8'd1;
                        end
                    end
                end

                LOCKED: begin
                    if (xfer) begin
                        if (!in_seq) begin
                            err_count  <= err_count_inc;
                            err_sticky <= 1'b1;
                            run_cnt    <= 8'd0;
                            state      <= HUNT;
                            locked     <= 1'b0;
                        end
                    end else if (idle_cnt == IDLE_LAST) begin
                        // Counter stops here and state leaves LOCKED, so it never wraps.
                        state  <= STALL;
                        locked <= 1'b0;
                        stall  <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end

                STALL: begin
                    if (xfer) begin
                        stall <= 1'b0;
                        if (in_seq) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            err_count  <= err_count_inc;
                            err_sticky <= 1'b1;
                            run_cnt    <= 8'd0;
                            state      <= HUNT;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icedemo_counter_checker.sv
// Self-checking bench for icedemo_counter_checker.
// A behavioural model tracks the expected status from the stream rules; a
// compare process checks every DUT output one step after each rising edge.
// Directed scenarios pin the model with literal expectations, then a
// randomized stream (good words, bad words, repeats, gaps, resets) runs.

module tb_icedemo_counter_checker;

    localparam int WIDTH      = 16;
    localparam int LOCK_COUNT = 4;
    localparam int TIMEOUT    = 10;
`ifdef ICEDEMO_CHECKER_THROTTLE_EN
    localparam bit THROTTLE = 1'b1;
`else
    localparam bit THROTTLE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             locked;
    logic             stall;
    logic             err_sticky;
    logic [7:0]       err_count;
    logic [WIDTH-1:0] last_word;
    logic [7:0]       leds;

    icedemo_counter_checker_if #(.WIDTH(WIDTH)) rif ();

    icedemo_counter_checker #(
        .WIDTH      (WIDTH),
        .LOCK_COUNT (LOCK_COUNT),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .recv       (rif.slave),
        .locked     (locked),
        .stall      (stall),
        .err_sticky (err_sticky),
        .err_count  (err_count),
        .last_word  (last_word),
        .leds       (leds)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_EMPTY, M_HUNT, M_LOCKED, M_STALL} mode_t;

    mode_t m_mode;
    int    m_last;
    int    m_run;
    int    m_idle;
    int    m_errs;
    bit    m_sticky;
    bit    m_tready;

    function automatic void model_accept(input int w);
        bit good;
        good = (w == ((m_last + 1) % 65536));
        case (m_mode)
            M_EMPTY: begin
                m_mode = M_HUNT;
                m_run  = 0;
            end
            M_HUNT: begin
                if (good) begin
                    m_run++;
                    if (m_run == LOCK_COUNT) m_mode = M_LOCKED;
                end else begin
                    m_run = 0;
                end
            end
            default: begin
                if (good) begin
                    m_mode = M_LOCKED;
                end else begin
                    m_errs   = (m_errs >= 255) ? 255 : m_errs + 1;
                    m_sticky = 1'b1;
                    m_run    = 0;
                    m_mode   = M_HUNT;
                end
            end
        endcase
        m_last = w;
        m_idle = 0;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_mode   = M_EMPTY;
            m_last   = 0;
            m_run    = 0;
            m_idle   = 0;
            m_errs   = 0;
            m_sticky = 1'b0;
            m_tready = !THROTTLE;
        end else begin
            if (rif.tvalid === 1'b1 && m_tready) begin
                model_accept(int'(rif.tdata));
            end else if (m_mode == M_LOCKED) begin
                m_idle++;
                if (m_idle >= TIMEOUT) m_mode = M_STALL;
            end
            if (THROTTLE) m_tready = !m_tready;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #1;
        if (resetn) begin
            check("tready",     32'(rif.tready), 32'(m_tready));
            check("locked",     32'(locked),     32'(m_mode == M_LOCKED));
            check("stall",      32'(stall),      32'(m_mode == M_STALL));
            check("err_sticky", 32'(err_sticky), 32'(m_sticky));
            check("err_count",  32'(err_count),  32'(m_errs));
            check("last_word",  32'(last_word),  32'(m_last));
            check("leds",       32'(leds),
                  32'({m_mode == M_LOCKED, m_mode == M_STALL, m_sticky, 5'(m_last >> 11)}));
        end
    end

    // ---------------- stimulus helpers ----------------
    // All helpers start and end just after a falling edge.
    task automatic send(input logic [15:0] w);
        bit ready_now;
        int guard;
        guard = 0;
        rif.tvalid = 1'b1;
        rif.tdata  = w;
        do begin
            ready_now = rif.tready;
            @(negedge clk);
            guard++;
        end while (!ready_now && guard < 8);
        if (!ready_now) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: word %0h not accepted within 8 cycles", w);
        end
        rif.tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        rif.tvalid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [15:0] cur;
        int          r;

        rif.tvalid = 1'b0;
        rif.tdata  = '0;
        resetn     = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_locked",     32'(locked),     32'h0);
        check("rst_stall",      32'(stall),      32'h0);
        check("rst_err_sticky", 32'(err_sticky), 32'h0);
        check("rst_err_count",  32'(err_count),  32'h0);
        check("rst_last_word",  32'(last_word),  32'h0);
        check("rst_leds",       32'(leds),       32'h0);
        check("rst_tready",     32'(rif.tready), 32'(!THROTTLE));
        resetn = 1'b1;
`ifdef ICEDEMO_CHECKER_THROTTLE_EN
        @(negedge clk);
        check("thr_ready_1", 32'(rif.tready), 32'h1);
        @(negedge clk);
        check("thr_ready_2", 32'(rif.tready), 32'h0);
        @(negedge clk);
        check("thr_ready_3", 32'(rif.tready), 32'h1);
`endif

        // Basic lock: 0x0010..0x0014
        for (int w = 'h10; w <= 'h13; w++) send(16'(w));
        check("basic_prelock", 32'(locked), 32'h0);
        send(16'h0014);
        check("basic_locked",  32'(locked),    32'h1);
        check("basic_errs",    32'(err_count), 32'h0);
        check("basic_led7",    32'(leds[7]),   32'h1);

        // Wrap: 0xFFEC..0x0005 after a fresh reset
        do_reset();
        cur = 16'hFFEC;
        repeat (26) begin
            send(cur);
            cur = cur + 16'd1;
        end
        check("wrap_locked", 32'(locked),    32'h1);
        check("wrap_errs",   32'(err_count), 32'h0);
        check("wrap_last",   32'(last_word), 32'h0005);

        // Mismatch while locked at 0x0100
        do_reset();
        for (int w = 'hFC; w <= 'h100; w++) send(16'(w));
        check("mis_prelock", 32'(locked), 32'h1);
        send(16'h0105);
        check("mis_locked", 32'(locked),     32'h0);
        check("mis_errs",   32'(err_count),  32'h1);
        check("mis_sticky", 32'(err_sticky), 32'h1);
        check("mis_last",   32'(last_word),  32'h0105);
        for (int w = 'h106; w <= 'h109; w++) send(16'(w));
        check("mis_relock", 32'(locked), 32'h1);

        // Stall after TIMEOUT idle cycles, then recovery with a correct word
        idle(TIMEOUT - 1);
        check("stall_early", 32'(stall),  32'h0);
        check("stall_lock",  32'(locked), 32'h1);
        idle(1);
        check("stall_set",    32'(stall),   32'h1);
        check("stall_unlock", 32'(locked),  32'h0);
        check("stall_led6",   32'(leds[6]), 32'h1);
        send(16'h010A);
        check("resume_locked", 32'(locked),    32'h1);
        check("resume_stall",  32'(stall),     32'h0);
        check("resume_errs",   32'(err_count), 32'h1);

        // Saturation: 300 mismatches, relocking between each
        cur = 16'h010A;
        for (int i = 0; i < 300; i++) begin
            cur = cur + 16'd3;
            send(cur);
            repeat (LOCK_COUNT) begin
                cur = cur + 16'd1;
                send(cur);
            end
        end
        check("sat_errs",   32'(err_count),  32'hFF);
        check("sat_sticky", 32'(err_sticky), 32'h1);

        // Reset asserted mid-transfer clears everything immediately
        rif.tvalid = 1'b1;
        rif.tdata  = 16'h5555;
        #2 resetn = 1'b0;
        #1;
        check("mid_locked", 32'(locked),     32'h0);
        check("mid_sticky", 32'(err_sticky), 32'h0);
        check("mid_errs",   32'(err_count),  32'h0);
        check("mid_last",   32'(last_word),  32'h0);
        check("mid_leds",   32'(leds),       32'h0);
        @(negedge clk);
        resetn = 1'b1;
        send(16'h1234);
        check("post_last",   32'(last_word),  32'h1234);
        check("post_errs",   32'(err_count),  32'h0);
        check("post_sticky", 32'(err_sticky), 32'h0);

        // Randomized stream around the wrap point
        do_reset();
        cur = 16'hFFE0;
        send(cur);
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70) begin
                cur = cur + 16'd1;
                send(cur);
            end else if (r < 78) begin
                cur = 16'($urandom_range(0, 65535));
                send(cur);
            end else if (r < 83) begin
                send(cur);
            end else if (r < 94) begin
                idle(int'($urandom_range(1, 4)));
            end else if (r < 99) begin
                idle(int'($urandom_range(TIMEOUT - 2, TIMEOUT + 2)));
            end else begin
                do_reset();
            end
        end

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
